control_stage: RTL and testbench

CONTROL_STAGE -- requirements
Module: control_stage

---
 rtl/control_stage.sv | 227 ++++++++++++++++++++++
 tb/tb_control_stage.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_stage.sv
// rtl/control_stage.sv - instruction decode control stage with load-use bubble insertion
//
// One-entry pipeline register holding the decoded control bundle of one
// instruction. A load whose destination is read by the next instruction
// causes one bubble to be inserted ahead of that instruction.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready upstream handshake
//   opcode, funct7    instruction[6:0] and instruction[31:25]
//   rs1, rs2, rd      register indices of the incoming instruction
//   flush             kill the held and the incoming instruction
//   out_valid/out_ready downstream handshake for the registered bundle
//   AttemptBranch .. Illegal, ALUOp, out_rd  registered control bundle
//   bubble_count      saturating count of inserted load-use bubbles
module control_stage #(
  parameter int REG_ADDR_W     = 5,
  parameter int ALUOP_W        = 3,
  parameter int ENABLE_M       = 0,
  parameter int LOAD_USE_STALL = 1,
  parameter int CNT_W          = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [6:0]            opcode,
  input  logic [6:0]            funct7,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  AttemptBranch,
  output logic                  IsJALR,
  output logic                  Jump,
  output logic                  RegWrite,
  output logic                  MemToReg,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic                  Immediate,
  output logic                  Auipc,
  output logic                  MulDiv,
  output logic                  Illegal,
  output logic [ALUOP_W-1:0]    ALUOp,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic [CNT_W-1:0]      bubble_count
);

  // Seven and more ALU operations are encoded, so narrower selects cannot work.
  if (ALUOP_W < 3) begin : g_bad_aluop_w
    $error("control_stage: ALUOP_W must be at least 3");
  end

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_NOP   = 7'b0000000;

  // Bit positions inside the packed control vector.
  localparam int C_AB  = 10;
  localparam int C_JR  = 9;
  localparam int C_J   = 8;
  localparam int C_RW  = 7;
  localparam int C_M2R = 6;
  localparam int C_MR  = 5;
  localparam int C_MW  = 4;
  localparam int C_IMM = 3;
  localparam int C_AU  = 2;
  localparam int C_MD  = 1;
  localparam int C_ILL = 0;

  logic [10:0]           w_ctl;
  logic [ALUOP_W-1:0]    w_alu;
  logic                  w_use_rs1;
  logic                  w_use_rs2;
  logic                  w_is_m;
  logic                  w_hazard;
  logic                  w_accept;

  logic                  r_valid;
  logic [10:0]           r_ctl;
  logic [ALUOP_W-1:0]    r_alu;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [CNT_W-1:0]      r_cnt;

  assign w_is_m = (funct7 == 7'b0000001);

  always_comb begin
    w_ctl     = '0;
    w_alu     = '0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    case (opcode)
      OP_R: begin
        w_ctl[C_RW] = 1'b1;
        w_use_rs1   = 1'b1;
        w_use_rs2   = 1'b1;
        if ((ENABLE_M != 0) && w_is_m) begin
          w_ctl[C_MD] = 1'b1;
          w_alu       = ALUOP_W'(7);
        end
      end
      OP_I: begin
        w_ctl[C_RW]  = 1'b1;
        w_ctl[C_IMM] = 1'b1;
        w_alu        = ALUOP_W'(1);
        w_use_rs1    = 1'b1;
      end
      OP_B: begin
        w_ctl[C_AB] = 1'b1;
        w_use_rs1   = 1'b1;
        w_use_rs2   = 1'b1;
      end
      OP_LOAD: begin
        w_ctl[C_RW]  = 1'b1;
        w_ctl[C_M2R] = 1'b1;
        w_ctl[C_MR]  = 1'b1;
        w_ctl[C_IMM] = 1'b1;
        w_alu        = ALUOP_W'(3);
        w_use_rs1    = 1'b1;
      end
      OP_STORE: begin
        w_ctl[C_MW]  = 1'b1;
        w_ctl[C_IMM] = 1'b1;
        w_alu        = ALUOP_W'(3);
        w_use_rs1    = 1'b1;
        w_use_rs2    = 1'b1;
      end
      OP_LUI: begin
        w_ctl[C_RW]  = 1'b1;
        w_ctl[C_IMM] = 1'b1;
        w_alu        = ALUOP_W'(2);
      end
      OP_AUIPC: begin
        w_ctl[C_RW]  = 1'b1;
        w_ctl[C_IMM] = 1'b1;
        w_ctl[C_AU]  = 1'b1;
        w_alu        = ALUOP_W'(5);
      end
      OP_JAL: begin
        w_ctl[C_RW] = 1'b1;
        w_ctl[C_J]  = 1'b1;
        w_alu       = ALUOP_W'(6);
      end
      OP_JALR: begin
        w_ctl[C_RW] = 1'b1;
        w_ctl[C_J]  = 1'b1;
        w_ctl[C_JR] = 1'b1;
        w_alu       = ALUOP_W'(6);
        w_use_rs1   = 1'b1;
      end
      OP_NOP: begin
      end
      default: begin
        w_ctl[C_ILL] = 1'b1;
      end
    endcase
  end

  // A held load writing a non-zero register that the incoming instruction reads.
  assign w_hazard = (LOAD_USE_STALL != 0) && in_valid && r_valid && r_ctl[C_MR] &&
                    (r_rd != '0) &&
                    ((w_use_rs1 && (rs1 == r_rd)) || (w_use_rs2 && (rs2 == r_rd)));

  assign in_ready = !flush && !w_hazard && (!r_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  // Outputs are zeroed whenever the register goes empty, so an invalid
  // bundle always reads as all zeros without extra gating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_ctl   <= '0;
      r_alu   <= '0;
      r_rd    <= '0;
      r_cnt   <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_ctl   <= '0;
      r_alu   <= '0;
      r_rd    <= '0;
    end else if (w_hazard && out_ready) begin
      r_valid <= 1'b0;
      r_ctl   <= '0;
      r_alu   <= '0;
      r_rd    <= '0;
      if (r_cnt != {CNT_W{1'b1}}) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_ctl   <= w_ctl;
      r_alu   <= w_alu;
      r_rd    <= rd;
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
      r_ctl   <= '0;
      r_alu   <= '0;
      r_rd    <= '0;
    end
  end

  assign out_valid     = r_valid;
  assign AttemptBranch = r_ctl[C_AB];
  assign IsJALR        = r_ctl[C_JR];
  assign Jump          = r_ctl[C_J];
  assign RegWrite      = r_ctl[C_RW];
  assign MemToReg      = r_ctl[C_M2R];
  assign MemRead       = r_ctl[C_MR];
  assign MemWrite      = r_ctl[C_MW];
  assign Immediate     = r_ctl[C_IMM];
  assign Auipc         = r_ctl[C_AU];
  assign MulDiv        = r_ctl[C_MD];
  assign Illegal       = r_ctl[C_ILL];
  assign ALUOp         = r_alu;
  assign out_rd        = r_rd;
  assign bubble_count  = r_cnt;

endmodule

// File: tb/tb_control_stage.sv
// tb/tb_control_stage.sv - self-checking bench for control_stage
module tb_control_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [4:0] rs1, rs2, rd;
  logic       flush;
  logic       out_ready;

  // a_: ENABLE_M=1, z_: ENABLE_M=0, s_: ENABLE_M=0 with a 2-bit bubble counter
  logic        a_in_ready, a_out_valid, z_in_ready, z_out_valid, s_in_ready, s_out_valid;
  logic [10:0] a_ctl, z_ctl, s_ctl;
  logic [2:0]  a_alu, z_alu, s_alu;
  logic [4:0]  a_rd, z_rd, s_rd;
  logic [15:0] a_cnt, z_cnt;
  logic [1:0]  s_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  control_stage #(.ENABLE_M(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .opcode(opcode), .funct7(funct7), .rs1(rs1), .rs2(rs2), .rd(rd),
    .flush(flush), .out_valid(a_out_valid), .out_ready(out_ready),
    .AttemptBranch(a_ctl[10]), .IsJALR(a_ctl[9]), .Jump(a_ctl[8]), .RegWrite(a_ctl[7]),
    .MemToReg(a_ctl[6]), .MemRead(a_ctl[5]), .MemWrite(a_ctl[4]), .Immediate(a_ctl[3]),
    .Auipc(a_ctl[2]), .MulDiv(a_ctl[1]), .Illegal(a_ctl[0]),
    .ALUOp(a_alu), .out_rd(a_rd), .bubble_count(a_cnt)
  );

  control_stage #(.ENABLE_M(0)) dut_z (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(z_in_ready),
    .opcode(opcode), .funct7(funct7), .rs1(rs1), .rs2(rs2), .rd(rd),
    .flush(flush), .out_valid(z_out_valid), .out_ready(out_ready),
    .AttemptBranch(z_ctl[10]), .IsJALR(z_ctl[9]), .Jump(z_ctl[8]), .RegWrite(z_ctl[7]),
    .MemToReg(z_ctl[6]), .MemRead(z_ctl[5]), .MemWrite(z_ctl[4]), .Immediate(z_ctl[3]),
    .Auipc(z_ctl[2]), .MulDiv(z_ctl[1]), .Illegal(z_ctl[0]),
    .ALUOp(z_alu), .out_rd(z_rd), .bubble_count(z_cnt)
  );

  control_stage #(.ENABLE_M(0), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .opcode(opcode), .funct7(funct7), .rs1(rs1), .rs2(rs2), .rd(rd),
    .flush(flush), .out_valid(s_out_valid), .out_ready(out_ready),
    .AttemptBranch(s_ctl[10]), .IsJALR(s_ctl[9]), .Jump(s_ctl[8]), .RegWrite(s_ctl[7]),
    .MemToReg(s_ctl[6]), .MemRead(s_ctl[5]), .MemWrite(s_ctl[4]), .Immediate(s_ctl[3]),
    .Auipc(s_ctl[2]), .MulDiv(s_ctl[1]), .Illegal(s_ctl[0]),
    .ALUOp(s_alu), .out_rd(s_rd), .bubble_count(s_cnt)
  );

  // ---------------- reference model ----------------
  logic        m_valid = 1'b0;
  logic [18:0] m_b1 = '0;   // {controls, ALUOp, rd} expected with M decode
  logic [18:0] m_b0 = '0;   // same without M decode
  int          m_cnt = 0;

  function automatic logic [18:0] ref_bundle(input logic [6:0] op, input logic [6:0] f7,
                                             input logic [4:0] d, input bit enm);
    logic ab, jr, j, rw, m2r, mr, mw, imm, au, md, il;
    int alu;
    logic [2:0] alu3;
    {ab, jr, j, rw, m2r, mr, mw, imm, au, md, il} = '0;
    alu = 0;
    case (op)
      7'b0110011: begin rw = 1; if (enm && f7 == 7'b0000001) begin md = 1; alu = 7; end end
      7'b0010011: begin rw = 1; imm = 1; alu = 1; end
      7'b1100011: begin ab = 1; end
      7'b0000011: begin rw = 1; m2r = 1; mr = 1; imm = 1; alu = 3; end
      7'b0100011: begin mw = 1; imm = 1; alu = 3; end
      7'b0110111: begin rw = 1; imm = 1; alu = 2; end
      7'b0010111: begin rw = 1; imm = 1; au = 1; alu = 5; end
      7'b1101111: begin rw = 1; j = 1; alu = 6; end
      7'b1100111: begin rw = 1; j = 1; jr = 1; alu = 6; end
      7'b0000000: begin end
      default:    begin il = 1; end
    endcase
    alu3 = alu[2:0];
    return {ab, jr, j, rw, m2r, mr, mw, imm, au, md, il, alu3, d};
  endfunction

  function automatic bit reads_rs1(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0010011, 7'b1100011, 7'b0000011, 7'b0100011, 7'b1100111};
  endfunction

  function automatic bit reads_rs2(input logic [6:0] op);
    return op inside {7'b0110011, 7'b1100011, 7'b0100011};
  endfunction

  function automatic bit model_hazard();
    logic [4:0] held_rd;
    bit held_load;
    held_rd   = m_b1[4:0];
    held_load = m_b1[13];
    return in_valid && m_valid && held_load && held_rd != 0 &&
           ((reads_rs1(opcode) && rs1 == held_rd) || (reads_rs2(opcode) && rs2 == held_rd));
  endfunction

  function automatic bit model_ready();
    return !flush && !model_hazard() && (!m_valid || out_ready);
  endfunction

  // Advance the model by one clock using the inputs present before the edge.
  task automatic tick();
    bit hz, rdy;
    if (rst) begin
      m_valid = 0; m_b1 = '0; m_b0 = '0; m_cnt = 0;
    end else begin
      hz  = model_hazard();
      rdy = model_ready();
      if (flush) begin
        m_valid = 0; m_b1 = '0; m_b0 = '0;
      end else if (hz && out_ready) begin
        m_valid = 0; m_b1 = '0; m_b0 = '0; m_cnt++;
      end else if (in_valid && rdy) begin
        m_valid = 1;
        m_b1 = ref_bundle(opcode, funct7, rd, 1'b1);
        m_b0 = ref_bundle(opcode, funct7, rd, 1'b0);
      end else if (m_valid && out_ready) begin
        m_valid = 0; m_b1 = '0; m_b0 = '0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    in_valid = 0; opcode = 0; funct7 = 0; rs1 = 0; rs2 = 0; rd = 0;
    flush = 0; out_ready = 1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [6:0] f7,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d);
    in_valid = 1; opcode = op; funct7 = f7; rs1 = s1; rs2 = s2; rd = d;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    set_idle();
    rst = 1;
    tick();
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", a_out_valid); end
    checks++; if ({a_ctl, a_alu, a_rd} !== 19'd0) begin failures++; $display("FAIL reset_bundle got=%0h exp=0", {a_ctl, a_alu, a_rd}); end
    checks++; if (a_cnt !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", a_cnt); end
    rst = 0;
  endtask

  task automatic test_load_use();
    do_reset();
    drive(7'b0000011, 7'd0, 5'd2, 5'd0, 5'd5);          // LW x5
    tick();
    checks++; if (a_out_valid !== 1'b1 || a_ctl !== 11'b00011101000 || a_alu !== 3'd3 || a_rd !== 5'd5) begin
      failures++; $display("FAIL lw_bundle got=%0b/%b/%0d/%0d exp=1/00011101000/3/5", a_out_valid, a_ctl, a_alu, a_rd); end
    drive(7'b0110011, 7'd0, 5'd5, 5'd1, 5'd6);          // ADD x6,x5,x1
    #1;
    checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL hazard_ready got=%0b exp=0", a_in_ready); end
    tick();
    checks++; if (a_out_valid !== 1'b0 || a_cnt !== 16'd1) begin
      failures++; $display("FAIL bubble got valid=%0b cnt=%0d exp valid=0 cnt=1", a_out_valid, a_cnt); end
    #1;
    checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL post_bubble_ready got=%0b exp=1", a_in_ready); end
    tick();
    checks++; if (a_out_valid !== 1'b1 || a_ctl !== 11'b00010000000 || a_alu !== 3'd0 || a_rd !== 5'd6 || a_cnt !== 16'd1) begin
      failures++; $display("FAIL add_after_bubble got=%0b/%b/%0d/%0d/%0d exp=1/00010000000/0/6/1", a_out_valid, a_ctl, a_alu, a_rd, a_cnt); end
    set_idle();
    tick();
  endtask

  task automatic test_load_x0();
    do_reset();
    drive(7'b0000011, 7'd0, 5'd2, 5'd0, 5'd0);          // LW x0
    tick();
    drive(7'b0110011, 7'd0, 5'd0, 5'd1, 5'd6);          // ADD x6,x0,x1
    #1;
    checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL x0_ready got=%0b exp=1", a_in_ready); end
    tick();
    checks++; if (a_out_valid !== 1'b1 || a_rd !== 5'd6 || a_ctl !== 11'b00010000000 || a_cnt !== 16'd0) begin
      failures++; $display("FAIL x0_back_to_back got=%0b/%0d/%b/%0d exp=1/6/00010000000/0", a_out_valid, a_rd, a_ctl, a_cnt); end
    set_idle();
    tick();
  endtask

  task automatic test_illegal();
    do_reset();
    drive(7'b1111111, 7'd0, 5'd0, 5'd0, 5'd3);
    tick();
    checks++; if (a_out_valid !== 1'b1 || a_ctl !== 11'b00000000001 || a_alu !== 3'd0) begin
      failures++; $display("FAIL illegal got=%0b/%b/%0d exp=1/00000000001/0", a_out_valid, a_ctl, a_alu); end
    set_idle();
    tick();
    checks++; if (a_out_valid !== 1'b0 || {a_ctl, a_alu, a_rd} !== 19'd0) begin
      failures++; $display("FAIL drain_zero got=%0b/%0h exp=0/0", a_out_valid, {a_ctl, a_alu, a_rd}); end
  endtask

  task automatic test_muldiv();
    do_reset();
    drive(7'b0110011, 7'b0000001, 5'd1, 5'd2, 5'd7);
    tick();
    checks++; if (a_ctl !== 11'b00010000010 || a_alu !== 3'd7) begin
      failures++; $display("FAIL muldiv_m1 got=%b/%0d exp=00010000010/7", a_ctl, a_alu); end
    checks++; if (z_ctl !== 11'b00010000000 || z_alu !== 3'd0) begin
      failures++; $display("FAIL muldiv_m0 got=%b/%0d exp=00010000000/0", z_ctl, z_alu); end
    set_idle();
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(7'b0010011, 7'd0, 5'd1, 5'd0, 5'd9);          // I-type
    tick();
    out_ready = 0;
    drive(7'b0110011, 7'd0, 5'd3, 5'd4, 5'd10);         // R-type waiting
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL stall_ready cycle=%0d got=%0b exp=0", i, a_in_ready); end
      tick();
      checks++; if (a_out_valid !== 1'b1 || a_ctl !== 11'b00010001000 || a_alu !== 3'd1 || a_rd !== 5'd9) begin
        failures++; $display("FAIL stall_hold cycle=%0d got=%0b/%b/%0d/%0d exp=1/00010001000/1/9", i, a_out_valid, a_ctl, a_alu, a_rd); end
    end
    out_ready = 1;
    #1;
    checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL release_ready got=%0b exp=1", a_in_ready); end
    tick();
    checks++; if (a_out_valid !== 1'b1 || a_ctl !== 11'b00010000000 || a_rd !== 5'd10) begin
      failures++; $display("FAIL release_transfer got=%0b/%b/%0d exp=1/00010000000/10", a_out_valid, a_ctl, a_rd); end
    set_idle();
    tick();
  endtask

  task automatic test_flush_hazard();
    do_reset();
    drive(7'b0000011, 7'd0, 5'd2, 5'd0, 5'd5);
    tick();
    drive(7'b0110011, 7'd0, 5'd5, 5'd1, 5'd6);
    flush = 1;
    #1;
    checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%0b exp=0", a_in_ready); end
    tick();
    checks++; if (a_out_valid !== 1'b0 || a_cnt !== 16'd0 || {a_ctl, a_alu, a_rd} !== 19'd0) begin
      failures++; $display("FAIL flush_hazard got=%0b/%0d/%0h exp=0/0/0", a_out_valid, a_cnt, {a_ctl, a_alu, a_rd}); end
    set_idle();
    tick();
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL flush_not_accepted got=%0b exp=0", a_out_valid); end
  endtask

  task automatic test_reset_midhandshake();
    do_reset();
    drive(7'b0010011, 7'd0, 5'd1, 5'd0, 5'd9);
    tick();
    out_ready = 0;
    drive(7'b0110111, 7'd0, 5'd0, 5'd0, 5'd11);         // LUI waiting
    tick();
    #2;
    rst = 1;
    #1;
    checks++; if (a_out_valid !== 1'b0 || {a_ctl, a_alu, a_rd} !== 19'd0) begin
      failures++; $display("FAIL async_reset got=%0b/%0h exp=0/0", a_out_valid, {a_ctl, a_alu, a_rd}); end
    tick();
    rst = 0;
    out_ready = 1;
    tick();
    checks++; if (a_out_valid !== 1'b1 || a_ctl !== 11'b00010001000 || a_alu !== 3'd2 || a_rd !== 5'd11) begin
      failures++; $display("FAIL first_after_reset got=%0b/%b/%0d/%0d exp=1/00010001000/2/11", a_out_valid, a_ctl, a_alu, a_rd); end
    set_idle();
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(7'b0000011, 7'd0, 5'd1, 5'd0, 5'd5);
      tick();
      drive(7'b0100011, 7'd0, 5'd2, 5'd5, 5'd0);        // store reading x5 via rs2
      tick();
      tick();
      set_idle();
      tick();
    end
    checks++; if (a_cnt !== 16'd5) begin failures++; $display("FAIL count_five got=%0d exp=5", a_cnt); end
    checks++; if (s_cnt !== 2'd3) begin failures++; $display("FAIL count_saturate got=%0d exp=3", s_cnt); end
  endtask

  task automatic test_random();
    logic [6:0] pool [10];
    bit exp_rdy;
    int exp_a, exp_s;
    pool = '{7'b0110011, 7'b0010011, 7'b1100011, 7'b0000011, 7'b0100011,
             7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000000};
    do_reset();
    for (int n = 0; n < 600; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      opcode    = ($urandom_range(0, 7) == 0) ? 7'($urandom) : pool[$urandom_range(0, 9)];
      opcode    = (opcode == 7'b0000011 || $urandom_range(0, 3) != 0) ? opcode : 7'b0000011;
      funct7    = ($urandom_range(0, 2) == 0) ? 7'b0000001 : 7'($urandom);
      rs1       = 5'($urandom_range(0, 3));
      rs2       = 5'($urandom_range(0, 3));
      rd        = 5'($urandom_range(0, 3));
      #1;
      exp_rdy = model_ready();
      checks++; if (a_in_ready !== exp_rdy) begin failures++; $display("FAIL rand_ready n=%0d got=%0b exp=%0b", n, a_in_ready, exp_rdy); end
      tick();
      exp_a = (m_cnt > 65535) ? 65535 : m_cnt;
      exp_s = (m_cnt > 3) ? 3 : m_cnt;
      checks++; if (a_out_valid !== m_valid || {a_ctl, a_alu, a_rd} !== m_b1) begin
        failures++; $display("FAIL rand_bundle_m n=%0d got=%0b/%0h exp=%0b/%0h", n, a_out_valid, {a_ctl, a_alu, a_rd}, m_valid, m_b1); end
      checks++; if (z_out_valid !== m_valid || {z_ctl, z_alu, z_rd} !== m_b0) begin
        failures++; $display("FAIL rand_bundle_nom n=%0d got=%0b/%0h exp=%0b/%0h", n, z_out_valid, {z_ctl, z_alu, z_rd}, m_valid, m_b0); end
      checks++; if (a_cnt !== 16'(exp_a) || s_cnt !== 2'(exp_s)) begin
        failures++; $display("FAIL rand_count n=%0d got=%0d/%0d exp=%0d/%0d", n, a_cnt, s_cnt, exp_a, exp_s); end
    end
    set_idle();
    tick();
  endtask

  initial begin
    rst = 1;
    set_idle();
    test_reset();
    test_load_use();
    test_load_x0();
    test_illegal();
    test_muldiv();
    test_backpressure();
    test_flush_hazard();
    test_reset_midhandshake();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
